// File: rtl/gf2_systolic_ge_array.sv
// Triangular systolic array computing the row-echelon form of a streamed GF(2) matrix.
// One pivot row per cell row; rows ripple down one cell row per cycle with their valid and clear markers.
module gf2_systolic_ge_array #(
   parameter int COLS = 4,
   parameter int PIV  = 3
) (
   input  logic                     clk,
   input  logic                     rst_b,
   input  logic                     start,
   input  logic                     in_valid,
   input  logic                     in_last,
   input  logic [COLS-1:0]          data,
   output logic                     busy,
   output logic                     done,
   output logic [$clog2(PIV+1)-1:0] rank,
   output logic                     full_rank,
   output logic [PIV*COLS-1:0]      ech
);
   localparam int RW = $clog2(PIV+1);
   localparam int NP = (PIV > 1) ? PIV - 1 : 1;

   typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

   state_t          state;
   logic [RW-1:0]   cnt;
   logic            acc_start;
   logic            row_vld;

   logic [COLS-1:0] s_q   [PIV];
   logic [PIV-1:0]  r_q;

   logic [COLS-1:0] a_x   [PIV];
   logic [COLS-1:0] o_x   [PIV];
   logic [COLS-1:0] s_eff [PIV];
   logic [PIV-1:0]  v_x, c_x, ov_x, ld_x, r_eff, lead;

   logic [COLS-1:0] a_p1  [NP];
   logic [NP-1:0]   vld_p1, clr_p1;

   logic [RW-1:0]   pop;

   assign acc_start = (state == IDLE) && start && in_valid;
   assign row_vld   = in_valid && (acc_start || (state == LOAD));
   assign busy      = (state != IDLE);

   // A start marker makes the cell see an empty triangle row while it processes the first matrix row.
   always_comb begin
      a_x[0] = data;
      v_x[0] = row_vld;
      c_x[0] = acc_start;
      for (int k = 1; k < PIV; k++) begin
         a_x[k] = a_p1[k-1];
         v_x[k] = vld_p1[k-1];
         c_x[k] = clr_p1[k-1];
      end
      for (int k = 0; k < PIV; k++) begin
         r_eff[k] = r_q[k] & ~c_x[k];
         s_eff[k] = c_x[k] ? '0 : s_q[k];
         lead[k]  = a_x[k][COLS-1-k];
         ld_x[k]  = v_x[k] & ~r_eff[k] & lead[k];
         o_x[k]   = (r_eff[k] & lead[k]) ? (a_x[k] ^ s_eff[k]) : a_x[k];
         ov_x[k]  = v_x[k] & ~ld_x[k];
      end
   end

   always_comb begin
      pop = '0;
      for (int k = 0; k < PIV; k++)
         pop = pop + RW'(r_q[k]);
   end

   // Cell state and inter-row pipeline stage
   always_ff @(posedge clk) begin
      if (!rst_b) begin
         r_q    <= '0;
         vld_p1 <= '0;
         clr_p1 <= '0;
         for (int k = 0; k < PIV; k++) s_q[k] <= '0;
         for (int k = 0; k < NP; k++) a_p1[k] <= '0;
      end else begin
         for (int k = 0; k < PIV; k++) begin
            if (ld_x[k]) begin
               r_q[k] <= 1'b1;
               s_q[k] <= a_x[k];
            end else if (c_x[k]) begin
               r_q[k] <= 1'b0;
               s_q[k] <= '0;
            end
         end
         for (int k = 0; k < PIV - 1; k++) begin
            a_p1[k]   <= o_x[k];
            vld_p1[k] <= ov_x[k];
            clr_p1[k] <= c_x[k];
         end
      end
   end

   // Control FSM; DRAIN waits for the last row to reach the bottom cell row
   always_ff @(posedge clk) begin
      if (!rst_b) begin
         state     <= IDLE;
         cnt       <= '0;
         done      <= 1'b0;
         rank      <= '0;
         full_rank <= 1'b0;
         ech       <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (acc_start) begin
                  cnt   <= '0;
                  state <= in_last ? DRAIN : LOAD;
               end
            end
            LOAD: begin
               if (in_valid && in_last) begin
                  cnt   <= '0;
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (cnt == RW'(PIV - 1)) begin
                  state     <= IDLE;
                  done      <= 1'b1;
                  rank      <= pop;
                  full_rank <= (pop == RW'(PIV));
                  for (int k = 0; k < PIV; k++)
                     ech[k*COLS +: COLS] <= s_q[k];
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_gf2_systolic_ge_array.sv
// Bench for gf2_systolic_ge_array: sequential GF(2) elimination model plus directed frames.
module tb_gf2_systolic_ge_array;
   localparam int COLS = 4;
   localparam int PIV  = 3;
   localparam int RW   = $clog2(PIV+1);
   localparam int NEVER = 1000000000;

   logic                clk = 1'b0;
   logic                rst_b = 1'b0;
   logic                start = 1'b0;
   logic                in_valid = 1'b0;
   logic                in_last = 1'b0;
   logic [COLS-1:0]     data = '0;
   logic                busy, done, full_rank;
   logic [RW-1:0]       rank;
   logic [PIV*COLS-1:0] ech;

   gf2_systolic_ge_array #(.COLS(COLS), .PIV(PIV)) dut (
      .clk(clk), .rst_b(rst_b), .start(start), .in_valid(in_valid),
      .in_last(in_last), .data(data), .busy(busy), .done(done),
      .rank(rank), .full_rank(full_rank), .ech(ech)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model: rows are eliminated one after another against the pivot rows found so far.
   typedef struct {
      int                  dc;
      int                  rk;
      logic [PIV*COLS-1:0] e;
   } res_t;

   logic [COLS-1:0]     m_s [PIV];
   logic                m_r [PIV];
   int                  m_state = 0;
   int                  m_start_cyc = NEVER;
   int                  m_end_cyc = NEVER;
   res_t                pend [$];
   int                  exp_rank = 0;
   logic [PIV*COLS-1:0] exp_ech = '0;
   logic                exp_full = 1'b0;
   int                  last_e = 0;

   task automatic model_clear();
      for (int k = 0; k < PIV; k++) begin
         m_s[k] = '0;
         m_r[k] = 1'b0;
      end
   endtask

   task automatic model_row(input logic [COLS-1:0] a_in);
      logic [COLS-1:0] a;
      bit placed;
      a = a_in;
      placed = 1'b0;
      for (int k = 0; k < PIV; k++) begin
         if (!placed && a[COLS-1-k]) begin
            if (!m_r[k]) begin
               m_s[k] = a;
               m_r[k] = 1'b1;
               placed = 1'b1;
            end else begin
               a = a ^ m_s[k];
            end
         end
      end
   endtask

   task automatic finish_frame(input int e);
      res_t r;
      r.dc = e + PIV;
      r.rk = 0;
      r.e  = '0;
      for (int k = 0; k < PIV; k++) begin
         if (m_r[k]) r.rk++;
         r.e[k*COLS +: COLS] = m_s[k];
      end
      pend.push_back(r);
      m_end_cyc = e + PIV;
      m_state = 2;
   endtask

   task automatic step(input logic st, input logic v, input logic last, input logic [COLS-1:0] d);
      int e;
      e = cyc + 1;
      if (m_state == 2 && e > m_end_cyc) m_state = 0;
      start = st; in_valid = v; in_last = last; data = d;
      if (m_state == 0) begin
         if (st && v) begin
            model_clear();
            m_start_cyc = e;
            m_end_cyc = NEVER;
            model_row(d);
            if (last) finish_frame(e);
            else m_state = 1;
         end
      end else if (m_state == 1 && v) begin
         model_row(d);
         if (last) finish_frame(e);
      end
      @(posedge clk);
      #1;
      if (v && last) last_e = cyc;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0);
   endtask

   task automatic wait_done();
      bit got;
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      check("done_timeout", got, 1'b1);
      check("done_latency", cyc - last_e, PIV);
      #1;
   endtask

   task automatic frame3(input logic [COLS-1:0] r0, input logic [COLS-1:0] r1, input logic [COLS-1:0] r2);
      step(1'b1, 1'b1, 1'b0, r0);
      step(1'b0, 1'b1, 1'b0, r1);
      step(1'b0, 1'b1, 1'b1, r2);
      wait_done();
   endtask

   task automatic do_reset();
      rst_b = 1'b0;
      start = 1'b0; in_valid = 1'b0; in_last = 1'b0; data = '0;
      @(posedge clk);
      #1;
      pend.delete();
      m_state = 0;
      m_start_cyc = NEVER;
      m_end_cyc = NEVER;
      exp_rank = 0;
      exp_ech = '0;
      exp_full = 1'b0;
      model_clear();
      @(posedge clk);
      #1;
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_rank", rank, 0);
      check("rst_full", full_rank, 1'b0);
      check("rst_ech", ech, 0);
      rst_b = 1'b1;
   endtask

   // Per-cycle comparison against the model
   initial begin
      logic exp_busy, exp_done;
      forever begin
         @(negedge clk);
         if (chk_en && rst_b) begin
            exp_done = (pend.size() > 0) && (pend[0].dc == cyc);
            if (exp_done) begin
               exp_rank = pend[0].rk;
               exp_ech  = pend[0].e;
               exp_full = (pend[0].rk == PIV);
               void'(pend.pop_front());
            end
            exp_busy = (cyc >= m_start_cyc) && (cyc < m_end_cyc);
            check("busy", busy, exp_busy);
            check("done", done, exp_done);
            check("rank", rank, exp_rank);
            check("full_rank", full_rank, exp_full);
            check("ech", ech, exp_ech);
         end
      end
   end

   initial begin
      model_clear();
      do_reset();
      chk_en = 1'b1;
      idle(2);

      frame3(4'b1000, 4'b0100, 4'b0010);
      check("id_rank", rank, 3);
      check("id_full", full_rank, 1'b1);
      check("id_ech", ech, 12'b0010_0100_1000);
      idle(1);

      frame3(4'b1100, 4'b0110, 4'b1010);
      check("dep_rank", rank, 2);
      check("dep_full", full_rank, 1'b0);
      check("dep_ech", ech, 12'b0000_0110_1100);
      idle(1);

      frame3(4'b0110, 4'b1001, 4'b0011);
      check("zl_rank", rank, 3);
      check("zl_ech", ech, 12'b0011_0110_1001);
      idle(1);

      step(1'b1, 1'b1, 1'b0, 4'b1000);
      step(1'b0, 1'b1, 1'b0, 4'b0100);
      do_reset();
      idle(1);
      frame3(4'b1010, 4'b0101, 4'b0011);
      check("post_rst_rank", rank, 3);
      check("post_rst_ech", ech, 12'b0011_0101_1010);
      idle(1);

      step(1'b1, 1'b1, 1'b0, 4'b1100);
      step(1'b0, 1'b0, 1'b0, 4'b0000);
      step(1'b0, 1'b1, 1'b0, 4'b1100);
      step(1'b1, 1'b1, 1'b0, 4'b0011);
      check("load_start_busy", busy, 1'b1);
      step(1'b0, 1'b0, 1'b0, 4'b0000);
      step(1'b0, 1'b1, 1'b0, 4'b0101);
      step(1'b0, 1'b1, 1'b1, 4'b1111);
      wait_done();
      check("bub_rank", rank, 3);
      check("bub_full", full_rank, 1'b1);
      idle(1);

      step(1'b1, 1'b1, 1'b1, 4'b1111);
      idle(PIV);
      check("b2b_first_done", done, 1'b1);
      check("b2b_first_ech", ech, 12'b0000_0000_1111);
      step(1'b1, 1'b1, 1'b0, 4'b0001);
      step(1'b0, 1'b1, 1'b0, 4'b0010);
      step(1'b0, 1'b1, 1'b1, 4'b0100);
      wait_done();
      check("b2b_rank", rank, 2);
      check("b2b_ech", ech, 12'b0010_0100_0000);
      idle(4);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
